// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a start/busy/done handshake.
// Requests containing a digit above 9 are rejected and reported with error=1 and bin_out=0.
module bcd_to_bin_seq #(
    parameter int unsigned NDIGITS = 2,
    parameter int unsigned BW      = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [BW-1:0]          bin_out,
    output logic                   error
);

    localparam int unsigned DW = 4 * NDIGITS;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state, state_nx;
    logic [DW-1:0] bcd_r, bcd_nx;
    logic [DW-1:0] bin_r, bin_nx;
    logic [DW-1:0] bcd_sh, bin_sh;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rej_r, rej_nx;
    logic          busy_nx, done_nx, error_nx;
    logic [BW-1:0] bin_out_nx;
    logic          in_bad;

    // Any input digit above 9 makes the request invalid.
    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then correct digits that became >= 8.
    always_comb begin
        {bcd_sh, bin_sh} = {bcd_r, bin_r} >> 1;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd_sh[4*i+3]) begin
                bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx   = state;
        bcd_nx     = bcd_r;
        bin_nx     = bin_r;
        cnt_nx     = cnt;
        rej_nx     = rej_r;
        bin_out_nx = bin_out;
        error_nx   = error;

        case (state)
            S_IDLE, S_DONE: begin
                if (rej_r) begin
                    // Rejected request is reported one cycle after its accepting edge.
                    rej_nx     = 1'b0;
                    state_nx   = S_DONE;
                    error_nx   = 1'b1;
                    bin_out_nx = '0;
                end else if (start && in_bad) begin
                    rej_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else if (start) begin
                    state_nx = S_CONV;
                    bcd_nx   = bcd_in;
                    bin_nx   = '0;
                    cnt_nx   = CW'(DW - 1);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CONV: begin
                bcd_nx = bcd_sh;
                bin_nx = bin_sh;
                cnt_nx = cnt - CW'(1);
                if (cnt == '0) begin
                    state_nx   = S_DONE;
                    bin_out_nx = BW'(bin_sh);
                    error_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx == S_CONV);
        done_nx = (state_nx == S_DONE);
    end

    // State, scratch and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            rej_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_nx;
            bcd_r   <= bcd_nx;
            bin_r   <= bin_nx;
            cnt     <= cnt_nx;
            rej_r   <= rej_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            bin_out <= bin_out_nx;
            error   <= error_nx;
        end
    end

endmodule
